// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style accumulator CPU: controller states,
// opcode encodings and a small state-class helper.
package sap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Stopped states: the only ones where the loader port and run are honoured.
  function automatic logic is_stopped(input state_t s);
    return (s == ST_IDLE) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Accumulator add/subtract unit. Subtract is A + ~B + 1, so carry-out set
// means "no borrow".
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;

  assign w_b     = i_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_sub};
  assign o_sum   = w_sum[DATA_W-1:0];
  assign o_carry = w_sum[DATA_W];
  assign o_zero  = (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/sap_n.sv
// Two-cycle (fetch/execute) accumulator CPU with a loadable unified RAM,
// carry/zero flags and a registered output port.
module sap_n
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic              r_c;
  logic              r_z;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_alu_sum;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_alu_sub;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_opcode  = r_ir[DATA_W-1 -: 4];
  assign w_addr    = r_ir[ADDR_W-1:0];
  assign w_imm     = {4'b0000, r_ir[DATA_W-5:0]};
  assign w_alu_sub = (w_opcode == OP_SUB);
  // One read port: instruction fetch in FETCH, operand read in EXEC.
  assign w_rd_addr = (r_state == ST_FETCH) ? r_pc : w_addr;
  assign w_rd_data = r_mem[w_rd_addr];

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == ST_HALT);
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a     (r_a),
    .i_b     (w_rd_data),
    .i_sub   (w_alu_sub),
    .o_sum   (w_alu_sum),
    .o_carry (w_alu_c),
    .o_zero  (w_alu_z)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = (w_opcode == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  w_state_nxt = run ? ST_FETCH : ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Loader and STA share the write port; they are never live in the same state.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = prog_addr;
    w_mem_wdata = prog_data;
    if (!rst_n) begin
      w_mem_we = 1'b0;
    end else if (is_stopped(r_state)) begin
      w_mem_we = prog_we;
    end else if ((r_state == ST_EXEC) && (w_opcode == OP_STA)) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_addr;
      w_mem_wdata = r_a;
    end else begin
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= {ADDR_W{1'b0}};
      r_ir        <= {DATA_W{1'b0}};
      r_a         <= {DATA_W{1'b0}};
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (run) begin
            r_pc <= {ADDR_W{1'b0}};
            r_a  <= {DATA_W{1'b0}};
            r_c  <= 1'b0;
            r_z  <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_ir <= w_rd_data;
          r_pc <= r_pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          case (w_opcode)
            OP_LDA: r_a <= w_rd_data;
            OP_ADD, OP_SUB: begin
              r_a <= w_alu_sum;
              r_c <= w_alu_c;
              r_z <= w_alu_z;
            end
            OP_LDI: r_a <= w_imm;
            OP_JMP: r_pc <= w_addr;
            OP_JC:  if (r_c) r_pc <= w_addr;
            OP_JZ:  if (r_z) r_pc <= w_addr;
            OP_OUT: begin
              r_out_data  <= r_a;
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
